// File: rtl/grf_mp.sv
// Multi-port general register file: two write ports (W1 wins), NUM_RD bypassed read ports, busy scoreboard.
// Optional write trace enabled by defining GRF_TRACE_EN.
module grf_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_we,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic [31:0]                wr0_pc,
    input  logic                       wr1_we,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic [31:0]                wr1_pc,
    input  logic                       iss_we,
    input  logic [ADDR_W-1:0]          iss_addr
);

    localparam int   DEPTH     = 1 << ADDR_W;
    localparam logic ZERO_EN_C = (ZERO_REG != 32'sd0);

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_EN_C && (addr == {ADDR_W{1'b0}});
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;

    logic w0_eff_s;
    logic w1_eff_s;
    logic iss_eff_s;
    logic w0_shadow_s;

    assign w0_eff_s    = wr0_we && !rst && !is_zero_reg(wr0_addr);
    assign w1_eff_s    = wr1_we && !rst && !is_zero_reg(wr1_addr);
    assign iss_eff_s   = iss_we && !rst && !is_zero_reg(iss_addr);
    // W0 is dropped when the younger stage writes the same register in the same cycle
    assign w0_shadow_s = w1_eff_s && (wr0_addr == wr1_addr);

    // Register storage update; reset clears every entry and discards same-cycle writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w0_eff_s && !w0_shadow_s) begin
                mem_r[wr0_addr] <= wr0_data;
            end
            if (w1_eff_s) begin
                mem_r[wr1_addr] <= wr1_data;
            end
        end
    end

    // Busy scoreboard: writeback clears, issue sets; the set is last so a new producer wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (w0_eff_s) begin
                busy_r[wr0_addr] <= 1'b0;
            end
            if (w1_eff_s) begin
                busy_r[wr1_addr] <= 1'b0;
            end
            if (iss_eff_s) begin
                busy_r[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;
        logic              hit0_s;
        logic              hit1_s;

        assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit0_s = w0_eff_s && (wr0_addr == addr_s);
        assign hit1_s = w1_eff_s && (wr1_addr == addr_s);

        // Read mux: reset, hardwired zero, W1 bypass, W0 bypass, then storage
        always_comb begin
            data_s = {DATA_W{1'b0}};
            busy_s = 1'b0;
            if (rst) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (is_zero_reg(addr_s)) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (hit1_s) begin
                data_s = wr1_data;
                busy_s = 1'b0;
            end else if (hit0_s) begin
                data_s = wr0_data;
                busy_s = 1'b0;
            end else begin
                data_s = mem_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_s;
        assign rd_busy[k]                  = busy_s;
    end

`ifdef GRF_TRACE_EN
    // Write trace, older stage first; a colliding W0 write is not reported
    always @(posedge clk) begin
        if (w0_eff_s && !w0_shadow_s) begin
            $display("%d@%h: $%d <= %h", $time, wr0_pc, wr0_addr, wr0_data);
        end
        if (w1_eff_s) begin
            $display("%d@%h: $%d <= %h", $time, wr1_pc, wr1_addr, wr1_data);
        end
    end
`else
    logic unused_pc_s;
    assign unused_pc_s = ^{wr0_pc, wr1_pc};
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp: stimulus queues expected read results, a negedge monitor compares them.
module tb_grf_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_we;
    logic [4:0]  wr0_addr;
    logic [31:0] wr0_data;
    logic [31:0] wr0_pc;
    logic        wr1_we;
    logic [4:0]  wr1_addr;
    logic [31:0] wr1_data;
    logic [31:0] wr1_pc;
    logic        iss_we;
    logic [4:0]  iss_addr;

    typedef struct {
        int          cyc;
        int          port;
        int          tag;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    grf_mp dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_we(wr0_we), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_pc(wr0_pc),
        .wr1_we(wr1_we), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_pc(wr1_pc),
        .iss_we(iss_we), .iss_addr(iss_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation due this cycle and compare against the live outputs
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc || rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy) begin
                errors++;
                $display("FAIL tag%0d port%0d cyc%0d: got data=%h busy=%b, want data=%h busy=%b",
                         e.tag, e.port, e.cyc, rd_data[e.port*32 +: 32], rd_busy[e.port], e.data, e.busy);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr0_we   = 1'b0;
        wr1_we   = 1'b0;
        iss_we   = 1'b0;
        wr0_addr = 5'd0;
        wr1_addr = 5'd0;
        iss_addr = 5'd0;
        wr0_data = 32'h0;
        wr1_data = 32'h0;
    endtask

    task automatic chk(input int port, input logic [4:0] a, input logic [31:0] d,
                       input logic b, input int tag);
        rd_addr[port*5 +: 5] = a;
        exp_q.push_back('{cyc, port, tag, d, b});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

    initial begin : stim
        int wait_cnt;
        rst = 1'b1;  rd_addr = 10'd0;
        wr0_we = 1'b0; wr0_addr = 5'd0; wr0_data = 32'h0; wr0_pc = 32'h0000_1000;
        wr1_we = 1'b0; wr1_addr = 5'd0; wr1_data = 32'h0; wr1_pc = 32'h0000_2000;
        iss_we = 1'b0; iss_addr = 5'd0;

        // Reset held, outputs forced to zero
        @(posedge clk); #1;
        rst = 1'b1;
        chk(0, 5'd5, 32'h0, 1'b0, 1);
        chk(1, 5'd7, 32'h0, 1'b0, 1);

        // Every register reads zero and idle after reset
        for (int i = 0; i < 32; i += 2) begin
            next_cycle();
            chk(0, 5'(i),     32'h0, 1'b0, 2);
            chk(1, 5'(i + 1), 32'h0, 1'b0, 2);
        end

        // W0 bypass, then storage
        next_cycle();
        wr0_we = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234_5678;
        chk(0, 5'd5, 32'h1234_5678, 1'b0, 3);
        chk(1, 5'd6, 32'h0,         1'b0, 3);
        next_cycle();
        chk(0, 5'd5, 32'h1234_5678, 1'b0, 4);
        chk(1, 5'd5, 32'h1234_5678, 1'b0, 4);

        // Same-address collision: W1 wins on bypass and in storage
        next_cycle();
        wr0_we = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA_0000;
        wr1_we = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5555_1111;
        chk(0, 5'd7, 32'h5555_1111, 1'b0, 5);
        chk(1, 5'd5, 32'h1234_5678, 1'b0, 5);
        next_cycle();
        chk(0, 5'd7, 32'h5555_1111, 1'b0, 6);
        chk(1, 5'd7, 32'h5555_1111, 1'b0, 6);

        // Independent writes on both ports, each bypassed
        next_cycle();
        wr0_we = 1'b1; wr0_addr = 5'd11; wr0_data = 32'h0000_0011;
        wr1_we = 1'b1; wr1_addr = 5'd12; wr1_data = 32'hDEAD_BEEF;
        chk(0, 5'd11, 32'h0000_0011, 1'b0, 7);
        chk(1, 5'd12, 32'hDEAD_BEEF, 1'b0, 7);
        next_cycle();
        chk(0, 5'd12, 32'hDEAD_BEEF, 1'b0, 8);
        chk(1, 5'd11, 32'h0000_0011, 1'b0, 8);

        // Register 0 ignores writes and issue
        next_cycle();
        wr1_we = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
        iss_we = 1'b1; iss_addr = 5'd0;
        chk(0, 5'd0, 32'h0, 1'b0, 9);
        chk(1, 5'd0, 32'h0, 1'b0, 9);
        next_cycle();
        chk(0, 5'd0, 32'h0, 1'b0, 10);
        chk(1, 5'd0, 32'h0, 1'b0, 10);

        // Scoreboard: issue, pending, clear by write, set-over-clear
        next_cycle();
        iss_we = 1'b1; iss_addr = 5'd9;
        chk(0, 5'd9, 32'h0, 1'b0, 11);
        chk(1, 5'd7, 32'h5555_1111, 1'b0, 11);
        next_cycle();
        chk(0, 5'd9, 32'h0, 1'b1, 12);
        chk(1, 5'd9, 32'h0, 1'b1, 12);
        next_cycle();
        wr0_we = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h0000_0042;
        chk(0, 5'd9, 32'h0000_0042, 1'b0, 13);
        chk(1, 5'd9, 32'h0000_0042, 1'b0, 13);
        next_cycle();
        chk(0, 5'd9, 32'h0000_0042, 1'b0, 14);
        chk(1, 5'd8, 32'h0, 1'b0, 14);
        next_cycle();
        iss_we = 1'b1; iss_addr = 5'd9;
        wr0_we = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h0000_0042;
        chk(0, 5'd9, 32'h0000_0042, 1'b0, 15);
        next_cycle();
        chk(0, 5'd9, 32'h0000_0042, 1'b1, 16);
        chk(1, 5'd9, 32'h0000_0042, 1'b1, 16);

        // Reset mid-operation discards issue and write, drops pending busy
        next_cycle();
        rst = 1'b1;
        iss_we = 1'b1; iss_addr = 5'd3;
        wr1_we = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h0000_0001;
        chk(0, 5'd4, 32'h0, 1'b0, 17);
        chk(1, 5'd9, 32'h0, 1'b0, 17);
        next_cycle();
        chk(0, 5'd4, 32'h0, 1'b0, 18);
        chk(1, 5'd3, 32'h0, 1'b0, 18);
        next_cycle();
        chk(0, 5'd9, 32'h0, 1'b0, 19);
        chk(1, 5'd5, 32'h0, 1'b0, 19);

        next_cycle();
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            errors += exp_q.size();
            $display("FAIL drain: pending=%0d, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
